gfx_cmd_sched: RTL and testbench
================================

// Module: gfx_cmd_sched
// PURPOSE
//  Shares the 24-bit graphics command port of the G10k core between two requesters:
//  the CPU device bus (32-bit words, device select in [31:30]) and an auxiliary engine
//  (sprite/texture updater). CPU commands are buffered in a FIFO.
//  Setup/data command sequences from one source are never interleaved with the other source.
//  Issue rate is paced for the core.
// PARAMETERS
//  DEVADDR       2'd2  device select matched against in[31:30]
//  FIFO_DEPTH    8     CPU command FIFO entries (power of 2, >=2)
//  MIN_GAP       1     idle cycles forced between two start pulses (0..15)
//  LOCK_TIMEOUT  64    cycles a lock may stay idle before forced release
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-low
//  in         in   32  CPU bus word; {dev[31:30], rsv[29:24], opcode[23:16], data[15:0]}
//  in_valid   in   1   CPU word valid this cycle
//  cpu_full   out  1   FIFO full; a CPU word written now is dropped
//  aux_req    in   1   aux command pending; held with aux_cmd until aux_gnt
//  aux_cmd    in   24  aux command {opcode[23:16], data[15:0]}
//  aux_gnt    out  1   1-cycle pulse; aux_cmd was issued this cycle
//  out        out  24  command to graphics core
//  start      out  1   1-cycle pulse; out valid
//  ovf        out  1   sticky: CPU word dropped on full FIFO
//  lock_to    out  1   sticky: lock released by timeout
// BEHAVIOUR
//  Reset (rst=0, async): out=0, start=0, aux_gnt=0, ovf=0, lock_to=0, FIFO empty,
//    state=IDLE, gap counter=0, round-robin pointer=CPU.
//  Push: a CPU word is accepted on a clock edge when in_valid=1, in[31:30]==DEVADDR and the FIFO is not full.
//    If the FIFO is full: the word is dropped and ovf is set.
//    If a push and a pop occur on the same edge while the FIFO is full, the push succeeds.
//  Latency: a CPU word sampled at edge N gives start=1 after edge N+1 at the earliest
//    (FIFO was empty, IDLE, gap expired). out/start/aux_gnt are registered.
//  Eligibility: issue only when the gap counter is 0.
//    The gap counter loads MIN_GAP on each issue and decrements to 0.
//    The aux source is ineligible in any cycle where aux_gnt=1, which prevents a double grant.
//  Setup opcodes (set SETUP_OPS: 3,6,7,10,11,15,16,18,19) acquire a lock for their source.
//    Any other opcode issued by the lock owner releases it.
//  FSM:
//    IDLE:     both ready -> serve the source other than the last-served one (round robin);
//              one ready -> serve it. A setup opcode moves to LOCK_CPU or LOCK_AUX.
//    LOCK_CPU: only the FIFO is served; aux waits. A non-setup opcode -> IDLE.
//    LOCK_AUX: only aux is served; the FIFO waits. A non-setup opcode -> IDLE.
//    In either LOCK state, if the owner is not ready for LOCK_TIMEOUT consecutive cycles:
//      -> IDLE and lock_to is set.
//  The idle counter resets on every issue by the owner; it does not count in IDLE.
//  No command is ever lost or duplicated except CPU words dropped on full.
//  A reset in mid-lock returns to IDLE with the FIFO flushed.
// CONFIGURATION
//  GFX_SCHED_STATS_EN defined:
//    adds outputs cnt_cpu[15:0], cnt_aux[15:0] (issued commands per source, wrapping)
//    and cnt_stall[15:0] (cycles a ready source was blocked by a lock, saturating at 16'hFFFF).
//    All counters reset to 0.
//  Undefined: these ports and counters do not exist. Core behaviour is identical either way.
// STRUCTURE
//  Package gfx_cmd_pkg:
//    opcode localparams (OP_TEX_ADDR=7 etc.)
//    is_setup(opcode) function
//    state encoding IDLE=2'd0, LOCK_CPU=2'd1, LOCK_AUX=2'd2
//    SRC_CPU/SRC_AUX constants
//  Sub-module gfx_cmd_fifo: synchronous FIFO, 24-bit wide, FIFO_DEPTH deep, full/empty flags,
//    same-edge push/pop. The arbiter FSM, pacing, timeout and flags live in gfx_cmd_sched.
// TESTING
//  1 Single CPU word in=32'h8005_0012, in_valid=1 for 1 cycle, MIN_GAP=1
//    -> start=1 with out=24'h050012 two edges later; aux_gnt stays 0.
//  2 Aux cmd 24'h0A0032 (setup) then 24'h0D0001, while the CPU pushes 24'h090055
//    -> order: 0A0032, 0D0001, 090055; no CPU issue between the two aux commands.
//  3 Both sources continuously ready with non-setup opcodes
//    -> issues alternate CPU/AUX; start spacing equals MIN_GAP+1 cycles.
//  4 Push 9 words with FIFO_DEPTH=8 and the core blocked by an aux lock
//    -> cpu_full=1 after the 8th push; the 9th word is dropped; ovf=1.
//    After release, exactly 8 words are issued in order.
//  5 Aux issues setup 24'h070003, then drops aux_req for 64 cycles
//    -> lock_to=1; state back to IDLE; the pending CPU word issues on the next eligible cycle.
//  6 rst pulled low mid LOCK_CPU with 3 words queued
//    -> all outputs 0 immediately; after release the FIFO is empty and no start occurs.

Source files
------------

// File: rtl/gfx_cmd_pkg.sv
// gfx_cmd_pkg
//   Shared definitions for the G10k command scheduler: opcode values, the
//   setup-opcode classifier, arbiter state encoding and source identifiers.
package gfx_cmd_pkg;

   // Setup opcodes: issuing one of these locks the port to its source
   localparam logic [7:0] OP_VIEWPORT = 8'd3;
   localparam logic [7:0] OP_SHADER   = 8'd6;
   localparam logic [7:0] OP_TEX_ADDR = 8'd7;
   localparam logic [7:0] OP_TEX_FMT  = 8'd10;
   localparam logic [7:0] OP_BLEND    = 8'd11;
   localparam logic [7:0] OP_SCISSOR  = 8'd15;
   localparam logic [7:0] OP_DEPTH    = 8'd16;
   localparam logic [7:0] OP_STENCIL  = 8'd18;
   localparam logic [7:0] OP_RASTER   = 8'd19;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCK_CPU = 2'd1,
      LOCK_AUX = 2'd2
   } state_t;

   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_AUX = 1'b1;

   function automatic logic is_setup(input logic [7:0] op);
      case (op)
         OP_VIEWPORT, OP_SHADER, OP_TEX_ADDR, OP_TEX_FMT, OP_BLEND,
         OP_SCISSOR, OP_DEPTH, OP_STENCIL, OP_RASTER: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/gfx_cmd_fifo.sv
// gfx_cmd_fifo
//   Synchronous first-word-fall-through FIFO for buffered CPU commands.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset (flushes pointers)
//     push, wdata  write strobe and data; accepted when not full or when
//                  popping on the same edge
//     pop, rdata   read strobe; rdata shows the head entry combinationally
//     full, empty  occupancy flags
module gfx_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when indices match
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, a same-edge pop frees the slot being written
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/gfx_cmd_sched.sv
// gfx_cmd_sched
//   Shares the 24-bit G10k command port between the CPU device bus (via a
//   FIFO) and the auxiliary engine. Setup opcodes lock the port to their
//   source until a non-setup opcode or an idle timeout; issues are paced
//   by a MIN_GAP idle-cycle counter.
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     in, in_valid        CPU bus word {dev,rsv,opcode,data} and its strobe
//     cpu_full            FIFO full (a word written now is dropped)
//     aux_req, aux_cmd    aux request, held until aux_gnt
//     aux_gnt             1-cycle pulse: aux_cmd issued
//     out, start          issued command and its 1-cycle valid pulse
//     ovf, lock_to        sticky: CPU word dropped / lock released by timeout
//   Optional (GFX_SCHED_STATS_EN): cnt_cpu, cnt_aux (wrapping issue counts),
//     cnt_stall (saturating cycles a ready source was blocked by a lock).
module gfx_cmd_sched
   import gfx_cmd_pkg::*;
#(
   parameter logic [1:0] DEVADDR      = 2'd2,
   parameter int         FIFO_DEPTH   = 8,
   parameter int         MIN_GAP      = 1,
   parameter int         LOCK_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in,
   input  logic        in_valid,
   output logic        cpu_full,
   input  logic        aux_req,
   input  logic [23:0] aux_cmd,
   output logic        aux_gnt,
   output logic [23:0] out,
   output logic        start,
   output logic        ovf,
   output logic        lock_to
`ifdef GFX_SCHED_STATS_EN
   ,
   output logic [15:0] cnt_cpu,
   output logic [15:0] cnt_aux,
   output logic [15:0] cnt_stall
`endif
);

   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);

   state_t       state;
   logic         last_src;
   logic [3:0]   gap_cnt;
   logic [TW-1:0] idle_cnt;

   logic         cpu_hit, fifo_push, fifo_full, fifo_empty;
   logic [23:0]  fifo_rdata;
   logic         cpu_rdy, aux_rdy, sel_cpu, sel_aux, issue;
   logic [23:0]  issue_cmd;
   logic         locked, owner_rdy, timeout;
   logic         unused_rsv;

   assign unused_rsv = ^in[29:24];

   assign cpu_hit   = in_valid && (in[31:30] == DEVADDR);
   // Push accepted on full only when the head is popped on the same edge
   assign fifo_push = cpu_hit && (!fifo_full || sel_cpu);
   assign cpu_full  = fifo_full;

   gfx_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (24)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (in[23:0]),
      .pop   (sel_cpu),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cpu_rdy = !fifo_empty;
   // aux_req is still high in the grant cycle; masking it avoids a re-grant
   assign aux_rdy = aux_req && !aux_gnt;

   always_comb begin
      sel_cpu = 1'b0;
      sel_aux = 1'b0;
      if (gap_cnt == 4'd0) begin
         case (state)
            IDLE: begin
               if (cpu_rdy && aux_rdy) begin
                  if (last_src == SRC_CPU) sel_aux = 1'b1;
                  else                     sel_cpu = 1'b1;
               end else begin
                  sel_cpu = cpu_rdy;
                  sel_aux = aux_rdy;
               end
            end
            LOCK_CPU: sel_cpu = cpu_rdy;
            LOCK_AUX: sel_aux = aux_rdy;
            default:  ;
         endcase
      end
   end

   assign issue     = sel_cpu || sel_aux;
   assign issue_cmd = sel_cpu ? fifo_rdata : aux_cmd;
   assign locked    = (state != IDLE);
   assign owner_rdy = (state == LOCK_CPU) ? cpu_rdy : aux_rdy;
   assign timeout   = locked && !owner_rdy && (idle_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_src <= SRC_CPU;
         gap_cnt  <= 4'd0;
         idle_cnt <= '0;
         out      <= 24'd0;
         start    <= 1'b0;
         aux_gnt  <= 1'b0;
         ovf      <= 1'b0;
         lock_to  <= 1'b0;
      end else begin
         start   <= issue;
         aux_gnt <= sel_aux;

         if (issue) begin
            out      <= issue_cmd;
            last_src <= sel_aux ? SRC_AUX : SRC_CPU;
            gap_cnt  <= 4'(MIN_GAP);
         end else if (gap_cnt != 4'd0) begin
            gap_cnt <= gap_cnt - 4'd1;
         end

         if (cpu_hit && fifo_full && !sel_cpu) ovf <= 1'b1;

         // Only the owner can issue while locked, so any issue decides the
         // next state from its own opcode alone
         if (issue) begin
            if (is_setup(issue_cmd[23:16])) state <= sel_aux ? LOCK_AUX : LOCK_CPU;
            else                            state <= IDLE;
            idle_cnt <= '0;
         end else if (timeout) begin
            state    <= IDLE;
            idle_cnt <= '0;
            lock_to  <= 1'b1;
         end else if (locked && !owner_rdy) begin
            idle_cnt <= idle_cnt + TO_ONE;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

`ifdef GFX_SCHED_STATS_EN
   logic blocked;
   assign blocked = ((state == LOCK_CPU) && aux_rdy) || ((state == LOCK_AUX) && cpu_rdy);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_cpu   <= 16'd0;
         cnt_aux   <= 16'd0;
         cnt_stall <= 16'd0;
      end else begin
         if (sel_cpu) cnt_cpu <= cnt_cpu + 16'd1;
         if (sel_aux) cnt_aux <= cnt_aux + 16'd1;
         if (blocked && (cnt_stall != 16'hFFFF)) cnt_stall <= cnt_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gfx_cmd_sched.sv
module tb_gfx_cmd_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in = 32'd0;
   logic        in_valid = 1'b0;
   logic        cpu_full;
   logic        aux_req = 1'b0;
   logic [23:0] aux_cmd = 24'd0;
   logic        aux_gnt;
   logic [23:0] out;
   logic        start;
   logic        ovf;
   logic        lock_to;
`ifdef GFX_SCHED_STATS_EN
   logic [15:0] cnt_cpu, cnt_aux, cnt_stall;
`endif

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;

   typedef struct {
      logic [23:0] cmd;
      logic        aux;
      int          cyc;
   } rec_t;
   rec_t iss_q[$];

   gfx_cmd_sched dut (
      .clk      (clk),
      .rst      (rst),
      .in       (in),
      .in_valid (in_valid),
      .cpu_full (cpu_full),
      .aux_req  (aux_req),
      .aux_cmd  (aux_cmd),
      .aux_gnt  (aux_gnt),
      .out      (out),
      .start    (start),
      .ovf      (ovf),
      .lock_to  (lock_to)
`ifdef GFX_SCHED_STATS_EN
      ,
      .cnt_cpu  (cnt_cpu),
      .cnt_aux  (cnt_aux),
      .cnt_stall(cnt_stall)
`endif
   );

   always #5 clk = ~clk;

   // Issue log: every start pulse with its source and edge number
   always @(posedge clk) begin
      cyc++;
      #1;
      if (start === 1'b1) iss_q.push_back('{cmd: out, aux: aux_gnt, cyc: cyc});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic aux_send(input logic [23:0] c);
      int n;
      aux_cmd = c;
      aux_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (aux_gnt !== 1'b1 && n < 200);
      aux_req = 1'b0;
      nchk++;
      if (aux_gnt !== 1'b1) begin
         nfail++;
         $display("FAIL aux_grant cmd=%h: aux_gnt=%b, required 1 within 200 cycles", c, aux_gnt);
      end
   endtask

   task automatic cpu_push(input logic [31:0] w);
      in = w;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_issues(input int cnt, input int budget);
      int n;
      n = 0;
      while (iss_q.size() < cnt && n < budget) begin
         @(negedge clk);
         n++;
      end
      nchk++;
      if (iss_q.size() < cnt) begin
         nfail++;
         $display("FAIL issue_wait: got %0d issues, required %0d", iss_q.size(), cnt);
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      nchk++; if (out !== 24'd0)  begin nfail++; $display("FAIL reset_out: got %h, required 000000", out); end
      nchk++; if (start !== 1'b0) begin nfail++; $display("FAIL reset_start: got %b, required 0", start); end
      nchk++; if (aux_gnt !== 1'b0) begin nfail++; $display("FAIL reset_aux_gnt: got %b, required 0", aux_gnt); end
      nchk++; if (ovf !== 1'b0 || lock_to !== 1'b0) begin nfail++; $display("FAIL reset_flags: ovf=%b lock_to=%b, required 0 0", ovf, lock_to); end
      nchk++; if (cpu_full !== 1'b0) begin nfail++; $display("FAIL reset_full: got %b, required 0", cpu_full); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      iss_q.delete();
      in = 32'h8005_0012;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      nchk++; if (start !== 1'b0) begin nfail++; $display("FAIL single_early: start=%b one edge after push, required 0", start); end
      @(negedge clk);
      nchk++; if (start !== 1'b1) begin nfail++; $display("FAIL single_start: got %b, required 1", start); end
      nchk++; if (out !== 24'h050012) begin nfail++; $display("FAIL single_out: got %h, required 050012", out); end
      nchk++; if (aux_gnt !== 1'b0) begin nfail++; $display("FAIL single_aux_gnt: got %b, required 0", aux_gnt); end
      @(negedge clk);
      nchk++; if (start !== 1'b0) begin nfail++; $display("FAIL single_pulse: got %b, required 0", start); end
      // Word for another device must be ignored
      cpu_push(32'h4005_0099);
      repeat (6) @(negedge clk);
      nchk++; if (iss_q.size() != 1) begin nfail++; $display("FAIL single_devsel: got %0d issues, required 1", iss_q.size()); end
   endtask

   task automatic test_aux_lock();
      iss_q.delete();
      fork
         begin
            aux_send(24'h0A0032);
            aux_send(24'h0D0001);
         end
         cpu_push(32'h8009_0055);
      join
      wait_issues(3, 50);
      repeat (4) @(negedge clk);
      nchk++; if (iss_q.size() != 3) begin nfail++; $display("FAIL lock_count: got %0d, required 3", iss_q.size()); end
      if (iss_q.size() >= 3) begin
         nchk++; if (iss_q[0].cmd !== 24'h0A0032 || iss_q[0].aux !== 1'b1) begin nfail++; $display("FAIL lock_first: got %h aux=%b, required 0a0032 aux=1", iss_q[0].cmd, iss_q[0].aux); end
         nchk++; if (iss_q[1].cmd !== 24'h0D0001 || iss_q[1].aux !== 1'b1) begin nfail++; $display("FAIL lock_second: got %h aux=%b, required 0d0001 aux=1", iss_q[1].cmd, iss_q[1].aux); end
         nchk++; if (iss_q[2].cmd !== 24'h090055 || iss_q[2].aux !== 1'b0) begin nfail++; $display("FAIL lock_third: got %h aux=%b, required 090055 aux=0", iss_q[2].cmd, iss_q[2].aux); end
      end
   endtask

   task automatic test_round_robin();
      iss_q.delete();
      fork
         for (int i = 0; i < 4; i++) aux_send(24'h0200A0 + 24'(i));
         for (int j = 0; j < 4; j++) cpu_push(32'h8001_0010 + 32'(j));
      join
      wait_issues(8, 50);
      repeat (4) @(negedge clk);
      nchk++; if (iss_q.size() != 8) begin nfail++; $display("FAIL rr_count: got %0d, required 8", iss_q.size()); end
      for (int k = 0; k < 8 && k < iss_q.size(); k++) begin
         logic        eaux;
         logic [23:0] ecmd;
         eaux = (k % 2 == 0);
         ecmd = eaux ? 24'h0200A0 + 24'(k / 2) : 24'h010010 + 24'(k / 2);
         nchk++;
         if (iss_q[k].cmd !== ecmd || iss_q[k].aux !== eaux) begin
            nfail++;
            $display("FAIL rr_order[%0d]: got %h aux=%b, required %h aux=%b", k, iss_q[k].cmd, iss_q[k].aux, ecmd, eaux);
         end
         if (k > 0) begin
            nchk++;
            if (iss_q[k].cyc - iss_q[k-1].cyc != 2) begin
               nfail++;
               $display("FAIL rr_spacing[%0d]: got %0d cycles, required 2", k, iss_q[k].cyc - iss_q[k-1].cyc);
            end
         end
      end
   endtask

   task automatic test_overflow();
      iss_q.delete();
      aux_send(24'h070003);
      for (int i = 0; i < 9; i++) begin
         cpu_push(32'h8001_0100 + 32'(i));
         if (i == 6) begin
            nchk++; if (cpu_full !== 1'b0) begin nfail++; $display("FAIL ovf_full7: got %b, required 0", cpu_full); end
         end
         if (i == 7) begin
            nchk++; if (cpu_full !== 1'b1) begin nfail++; $display("FAIL ovf_full8: got %b, required 1", cpu_full); end
            nchk++; if (ovf !== 1'b0) begin nfail++; $display("FAIL ovf_early: got %b, required 0", ovf); end
         end
      end
      nchk++; if (ovf !== 1'b1) begin nfail++; $display("FAIL ovf_set: got %b, required 1", ovf); end
      nchk++; if (iss_q.size() != 1) begin nfail++; $display("FAIL ovf_locked: got %0d issues, required 1", iss_q.size()); end
      aux_send(24'h0D0002);
      wait_issues(10, 100);
      repeat (10) @(negedge clk);
      nchk++; if (iss_q.size() != 10) begin nfail++; $display("FAIL ovf_count: got %0d, required 10", iss_q.size()); end
      if (iss_q.size() >= 10) begin
         nchk++; if (iss_q[1].cmd !== 24'h0D0002) begin nfail++; $display("FAIL ovf_release: got %h, required 0d0002", iss_q[1].cmd); end
         for (int k = 0; k < 8; k++) begin
            nchk++;
            if (iss_q[k+2].cmd !== 24'h010100 + 24'(k) || iss_q[k+2].aux !== 1'b0) begin
               nfail++;
               $display("FAIL ovf_drain[%0d]: got %h, required %h", k, iss_q[k+2].cmd, 24'h010100 + 24'(k));
            end
         end
      end
      nchk++; if (cpu_full !== 1'b0) begin nfail++; $display("FAIL ovf_empty: cpu_full=%b, required 0", cpu_full); end
   endtask

   task automatic test_timeout();
      int n;
      int tcyc;
      iss_q.delete();
      nchk++; if (lock_to !== 1'b0) begin nfail++; $display("FAIL to_pre: got %b, required 0", lock_to); end
      aux_send(24'h070003);
      cpu_push(32'h8005_0077);
      n = 0;
      while (lock_to !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      tcyc = cyc;
      nchk++; if (lock_to !== 1'b1) begin nfail++; $display("FAIL to_set: got %b, required 1", lock_to); end
      nchk++; if (iss_q.size() != 1) begin nfail++; $display("FAIL to_blocked: got %0d issues, required 1", iss_q.size()); end
      if (iss_q.size() >= 1) begin
         nchk++;
         if (tcyc - iss_q[0].cyc != 64) begin
            nfail++;
            $display("FAIL to_length: got %0d cycles, required 64", tcyc - iss_q[0].cyc);
         end
      end
      @(negedge clk);
      nchk++; if (iss_q.size() != 2) begin nfail++; $display("FAIL to_cpu_count: got %0d, required 2", iss_q.size()); end
      if (iss_q.size() >= 2) begin
         nchk++;
         if (iss_q[1].cmd !== 24'h050077 || iss_q[1].cyc != tcyc + 1) begin
            nfail++;
            $display("FAIL to_cpu_issue: got %h at +%0d, required 050077 at +1", iss_q[1].cmd, iss_q[1].cyc - tcyc);
         end
      end
   endtask

   task automatic test_reset_mid_lock();
      iss_q.delete();
      cpu_push(32'h8003_0001);
      cpu_push(32'h8006_0002);
      cpu_push(32'h8007_0003);
      cpu_push(32'h800A_0004);
      cpu_push(32'h800B_0005);
      nchk++; if (iss_q.size() != 2) begin nfail++; $display("FAIL rstlk_pre: got %0d issues, required 2", iss_q.size()); end
      nchk++; if (out !== 24'h060002) begin nfail++; $display("FAIL rstlk_out_pre: got %h, required 060002", out); end
      rst = 1'b0;
      #1;
      nchk++; if (out !== 24'd0 || start !== 1'b0 || aux_gnt !== 1'b0) begin nfail++; $display("FAIL rstlk_outputs: out=%h start=%b aux_gnt=%b, required 0", out, start, aux_gnt); end
      nchk++; if (ovf !== 1'b0 || lock_to !== 1'b0 || cpu_full !== 1'b0) begin nfail++; $display("FAIL rstlk_flags: ovf=%b lock_to=%b full=%b, required 0", ovf, lock_to, cpu_full); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      iss_q.delete();
      repeat (10) @(negedge clk);
      nchk++; if (iss_q.size() != 0) begin nfail++; $display("FAIL rstlk_flush: got %0d issues, required 0", iss_q.size()); end
      cpu_push(32'h8001_0999);
      repeat (3) @(negedge clk);
      nchk++; if (iss_q.size() != 1) begin nfail++; $display("FAIL rstlk_after_count: got %0d, required 1", iss_q.size()); end
      if (iss_q.size() >= 1) begin
         nchk++; if (iss_q[0].cmd !== 24'h010999) begin nfail++; $display("FAIL rstlk_after_cmd: got %h, required 010999", iss_q[0].cmd); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_aux_lock();
      test_round_robin();
      test_overflow();
      test_timeout();
      test_reset_mid_lock();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
